serdes_framed: RTL and testbench
================================

Name: serdes_framed

Overview:
Parametrised, framed successor to the 8-bit SERDES core.
- TX serialises a WIDTH-bit parallel word into a self-delimiting frame: start bit, data, optional even parity, stop bit.
- RX hunts for the start bit, deserialises the word and checks parity.
- Internal loopback lets the tile self-test with no external wiring.
- Sits between the tile's parallel pins and its one-bit serial pins.

Parameters:
WIDTH, 8, data bits per frame (2..32)
MSB_FIRST, 1, 1 = transmit/receive bit WIDTH-1 first; 0 = bit 0 first
PARITY_EN, 1, 1 = append/check even parity bit; 0 = no parity bit

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tx_data  input  WIDTH  word to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  TX can accept a word this cycle
tx_busy  output  1  TX frame in progress (any state other than IDLE)
ser_out  output  1  serial line out, registered
ser_in  input  1  serial line in, synchronous to clk (no internal synchroniser)
loopback  input  1  1 = RX samples ser_out instead of ser_in
rx_data  output  WIDTH  last received word; held until next rx_valid
rx_valid  output  1  one-cycle pulse, new word on rx_data
rx_perr  output  1  parity error for current rx_data; valid with rx_valid, held with rx_data

Behaviour:
- Reset (async, rst_n=0):
  - TX returns to IDLE, RX to HUNT.
  - ser_out=0, tx_ready=1 once rst_n deasserts, tx_busy=0, rx_valid=0, rx_perr=0, rx_data=0.
  - Bit counters and shift registers are cleared.
  - Reset mid-frame aborts both directions; no partial rx_valid is issued.
- Line format: idle and stop level is 0; start bit is 1; then WIDTH data bits in MSB_FIRST order; then parity bit if PARITY_EN (XOR of data bits, i.e. even parity); then one stop bit (0).
- TX FSM states: IDLE, START, DATA, PAR, STOP. ser_out is driven from state.
  - IDLE: tx_ready=1, ser_out=0. Handshake occurs when tx_valid & tx_ready at a clock edge; tx_data is captured into the shift register, next state START.
  - START: ser_out=1, next state DATA.
  - DATA: one bit per cycle for WIDTH cycles. Next state is PAR if PARITY_EN, else STOP.
  - PAR: ser_out=parity, next state STOP.
  - STOP: ser_out=0, next state IDLE.
  - tx_ready=0 in every state except IDLE.
  - Frame period, handshake to next tx_ready: WIDTH+PARITY_EN+3 cycles.
  - tx_data changes after the handshake have no effect.
- RX FSM states: HUNT, DATA, PAR. rx_src = loopback ? ser_out : ser_in, sampled every rising edge.
  - HUNT: sampled 1 -> DATA with bit count 0. Sampled 0 -> stay in HUNT.
  - DATA: shift in WIDTH samples in MSB_FIRST order. Then go to PAR if PARITY_EN; otherwise load rx_data, pulse rx_valid and return to HUNT.
  - PAR: sample the parity bit. rx_perr = sample XOR (XOR of data bits). Load rx_data, pulse rx_valid, return to HUNT.
  - With PARITY_EN=0, rx_perr is tied to 0.
  - The stop bit is absorbed in HUNT. A missing stop bit (line 1) is taken as the next start bit.
- Latency (loopback): rx_valid is high in the cycle ser_out shows STOP, i.e. handshake edge + WIDTH+PARITY_EN+2 cycles.
- Changing loopback mid-frame takes effect on the next sample and is not guarded.
- tx_valid=1 held continuously gives back-to-back frames separated by exactly one IDLE cycle.

Test Plan:
- WIDTH=8, MSB_FIRST=1, PARITY_EN=1, loopback=1, send 0xA5 -> ser_out = 1,1,0,1,0,0,1,0,1,0,0; rx_valid 11 cycles after handshake; rx_data=0xA5; rx_perr=0.
- loopback=0, drive ser_in with frame 1, 0x3C bits, parity 1 (wrong) -> rx_data=0x3C, rx_perr=1, single rx_valid pulse.
- tx_valid held high with 0x01 then 0xFF -> tx_ready pulses every 12 cycles; rx_valid twice with 0x01/perr=0 and 0xFF/perr=0.
- Assert rst_n=0 during DATA bit 4 of 0x5A -> ser_out=0 and tx_busy=0 immediately; no rx_valid; next frame 0x81 received correctly.
- WIDTH=16, MSB_FIRST=0, PARITY_EN=0, loopback send 0x1234 -> first data bit on ser_out is 0; rx_valid after 18 cycles; rx_data=0x1234; rx_perr=0.
- tx_valid=0 for 50 cycles -> ser_out=0, tx_ready=1, no rx_valid.

Source files
------------

// File: rtl/serdes_framed.sv
// Framed serialiser/deserialiser: start bit, WIDTH data bits, optional even parity, stop bit.
// Idle and stop level is 0. The receiver can be looped back onto the local transmitter.
module serdes_framed #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_busy,
    output logic             ser_out,
    input  logic             ser_in,
    input  logic             loopback,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_perr
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_HUNT, RX_DATA, RX_PAR} rx_state_t;

    tx_state_t        tx_state, tx_state_nx;
    logic [WIDTH-1:0] tx_sh, tx_sh_nx;
    logic [CW-1:0]    tx_cnt, tx_cnt_nx;
    logic             tx_par, tx_par_nx;
    logic             ser_out_nx;

    rx_state_t        rx_state, rx_state_nx;
    logic [WIDTH-1:0] rx_sh, rx_sh_nx, rx_shifted;
    logic [CW-1:0]    rx_cnt, rx_cnt_nx;
    logic [WIDTH-1:0] rx_data_nx;
    logic             rx_valid_nx, rx_perr_nx;
    logic             rx_src;

    assign tx_ready = (tx_state == TX_IDLE);
    assign tx_busy  = (tx_state != TX_IDLE);
    assign rx_src   = loopback ? ser_out : ser_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_sh    <= '0;
            tx_cnt   <= '0;
            tx_par   <= 1'b0;
            ser_out  <= 1'b0;
        end else begin
            tx_state <= tx_state_nx;
            tx_sh    <= tx_sh_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_par   <= tx_par_nx;
            ser_out  <= ser_out_nx;
        end
    end

    // ser_out_nx is the line level for the state being entered, so ser_out tracks tx_state.
    always_comb begin
        tx_state_nx = tx_state;
        tx_sh_nx    = tx_sh;
        tx_cnt_nx   = tx_cnt;
        tx_par_nx   = tx_par;
        ser_out_nx  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_state_nx = TX_START;
                    tx_sh_nx    = tx_data;
                    tx_par_nx   = ^tx_data;
                    ser_out_nx  = 1'b1;
                end
            end
            TX_START: begin
                tx_state_nx = TX_DATA;
                tx_cnt_nx   = '0;
                ser_out_nx  = (MSB_FIRST != 0) ? tx_sh[WIDTH-1] : tx_sh[0];
            end
            TX_DATA: begin
                if (tx_cnt == LAST) begin
                    if (PARITY_EN != 0) begin
                        tx_state_nx = TX_PAR;
                        ser_out_nx  = tx_par;
                    end else begin
                        tx_state_nx = TX_STOP;
                    end
                end else begin
                    tx_cnt_nx = tx_cnt + CW'(1);
                    if (MSB_FIRST != 0) begin
                        tx_sh_nx   = {tx_sh[WIDTH-2:0], 1'b0};
                        ser_out_nx = tx_sh[WIDTH-2];
                    end else begin
                        tx_sh_nx   = {1'b0, tx_sh[WIDTH-1:1]};
                        ser_out_nx = tx_sh[1];
                    end
                end
            end
            TX_PAR:  tx_state_nx = TX_STOP;
            TX_STOP: tx_state_nx = TX_IDLE;
            default: tx_state_nx = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_HUNT;
            rx_sh    <= '0;
            rx_cnt   <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_perr  <= 1'b0;
        end else begin
            rx_state <= rx_state_nx;
            rx_sh    <= rx_sh_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_data  <= rx_data_nx;
            rx_valid <= rx_valid_nx;
            rx_perr  <= rx_perr_nx;
        end
    end

    // The stop bit is simply absorbed by HUNT; a 1 there starts the next frame.
    always_comb begin
        rx_state_nx = rx_state;
        rx_sh_nx    = rx_sh;
        rx_cnt_nx   = rx_cnt;
        rx_data_nx  = rx_data;
        rx_valid_nx = 1'b0;
        rx_perr_nx  = rx_perr;
        if (MSB_FIRST != 0) rx_shifted = {rx_sh[WIDTH-2:0], rx_src};
        else                rx_shifted = {rx_src, rx_sh[WIDTH-1:1]};
        case (rx_state)
            RX_HUNT: begin
                if (rx_src) begin
                    rx_state_nx = RX_DATA;
                    rx_cnt_nx   = '0;
                end
            end
            RX_DATA: begin
                rx_sh_nx = rx_shifted;
                if (rx_cnt == LAST) begin
                    if (PARITY_EN != 0) begin
                        rx_state_nx = RX_PAR;
                    end else begin
                        rx_state_nx = RX_HUNT;
                        rx_data_nx  = rx_shifted;
                        rx_valid_nx = 1'b1;
                        rx_perr_nx  = 1'b0;
                    end
                end else begin
                    rx_cnt_nx = rx_cnt + CW'(1);
                end
            end
            RX_PAR: begin
                rx_state_nx = RX_HUNT;
                rx_data_nx  = rx_sh;
                rx_valid_nx = 1'b1;
                rx_perr_nx  = rx_src ^ (^rx_sh);
            end
            default: rx_state_nx = RX_HUNT;
        endcase
    end

endmodule

// File: tb/tb_serdes_framed.sv
// Bench for serdes_framed: two configurations driven together, checked every cycle against a
// frame-level model, plus directed scenarios with hand-computed expectations.
module tb_serdes_framed;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_valid = 1'b0;
    logic        loopback = 1'b1;
    logic        ser_in = 1'b0;
    logic [7:0]  tx_data0 = '0;
    logic [15:0] tx_data1 = '0;

    logic        tx_ready0, tx_busy0, ser_out0, rx_valid0, rx_perr0;
    logic [7:0]  rx_data0;
    logic        tx_ready1, tx_busy1, ser_out1, rx_valid1, rx_perr1;
    logic [15:0] rx_data1;

    always #5 clk = ~clk;

    serdes_framed #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data0), .tx_valid(tx_valid),
        .tx_ready(tx_ready0), .tx_busy(tx_busy0), .ser_out(ser_out0), .ser_in(ser_in),
        .loopback(loopback), .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_perr(rx_perr0));

    serdes_framed #(.WIDTH(16), .MSB_FIRST(0), .PARITY_EN(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid),
        .tx_ready(tx_ready1), .tx_busy(tx_busy1), .ser_out(ser_out1), .ser_in(ser_in),
        .loopback(loopback), .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_perr(rx_perr1));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: the transmitter replays a precomputed bit list, the receiver
    // collects line samples after a 1 and decodes them once the frame length is reached.
    int          mw[2]  = '{8, 16};
    int          mmf[2] = '{1, 0};
    int          mpe[2] = '{1, 0};
    bit          m_out[2];
    bit          m_busy[2];
    bit          m_frame[2][0:40];
    int          m_fpos[2];
    int          m_flen[2];
    int          r_pos[2];
    bit          r_bits[2][0:40];
    bit          e_rv[2];
    logic [31:0] e_rd[2];
    bit          e_rp[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_out[k]  = 1'b0;
            m_busy[k] = 1'b0;
            m_fpos[k] = 0;
            m_flen[k] = 0;
            r_pos[k]  = -1;
            e_rv[k]   = 1'b0;
            e_rd[k]   = '0;
            e_rp[k]   = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic [31:0] d);
        bit          src;
        bit          p;
        logic [31:0] w;
        src = loopback ? m_out[k] : ser_in;
        e_rv[k] = 1'b0;
        if (r_pos[k] < 0) begin
            if (src) r_pos[k] = 0;
        end else begin
            r_bits[k][r_pos[k]] = src;
            r_pos[k]++;
            if (r_pos[k] == mw[k] + mpe[k]) begin
                w = '0;
                p = 1'b0;
                for (int i = 0; i < mw[k]; i++) begin
                    if (mmf[k] != 0) w[mw[k]-1-i] = r_bits[k][i];
                    else             w[i]         = r_bits[k][i];
                    p ^= r_bits[k][i];
                end
                e_rd[k] = w;
                e_rp[k] = (mpe[k] != 0) ? (r_bits[k][mw[k]] ^ p) : 1'b0;
                e_rv[k] = 1'b1;
                r_pos[k] = -1;
            end
        end
        if (m_busy[k]) begin
            m_fpos[k]++;
            if (m_fpos[k] < m_flen[k]) m_out[k] = m_frame[k][m_fpos[k]];
            else begin
                m_busy[k] = 1'b0;
                m_out[k]  = 1'b0;
            end
        end else if (tx_valid) begin
            p = 1'b0;
            m_frame[k][0] = 1'b1;
            for (int i = 0; i < mw[k]; i++) begin
                m_frame[k][1+i] = (mmf[k] != 0) ? d[mw[k]-1-i] : d[i];
                p ^= d[i];
            end
            m_flen[k] = mw[k] + mpe[k] + 2;
            if (mpe[k] != 0) m_frame[k][mw[k]+1] = p;
            m_frame[k][m_flen[k]-1] = 1'b0;
            m_fpos[k] = 0;
            m_busy[k] = 1'b1;
            m_out[k]  = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else begin
                model_step(0, {24'b0, tx_data0});
                model_step(1, {16'b0, tx_data1});
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("w8 ctl {ser_out,ready,busy,rx_valid}",
                  32'({ser_out0, tx_ready0, tx_busy0, rx_valid0}),
                  32'({m_out[0], !m_busy[0], m_busy[0], e_rv[0]}));
            check("w8 rx {perr,data}", 32'({rx_perr0, rx_data0}), 32'({e_rp[0], e_rd[0][7:0]}));
            check("w16 ctl {ser_out,ready,busy,rx_valid}",
                  32'({ser_out1, tx_ready1, tx_busy1, rx_valid1}),
                  32'({m_out[1], !m_busy[1], m_busy[1], e_rv[1]}));
            check("w16 rx {perr,data}", 32'({rx_perr1, rx_data1}), 32'({e_rp[1], e_rd[1][15:0]}));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [10:0] seq;
    logic [9:0]  fb;
    logic [7:0]  got;
    logic        gp;
    logic        first1;
    int          v0, v1, n, bad;
    logic [7:0]  got_d[4];
    logic        got_p[4];
    int          got_c[4];

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("reset ser_out", 32'(ser_out0), 32'(0));
        check("reset tx_ready", 32'(tx_ready0), 32'(1));
        check("reset tx_busy", 32'(tx_busy0), 32'(0));
        check("reset rx_data", 32'(rx_data0), 32'(0));
        check("reset rx_perr", 32'(rx_perr0), 32'(0));
        tick();

        // Loopback 0xA5 on the 8-bit unit, 0x1234 on the 16-bit LSB-first unit.
        loopback = 1'b1;
        tx_valid = 1'b1;
        tx_data0 = 8'hA5;
        tx_data1 = 16'h1234;
        tick();
        tx_valid = 1'b0;
        seq = '0; v0 = 0; v1 = 0; first1 = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c <= 11) seq = {seq[9:0], ser_out0};
            if (rx_valid0) v0 = c;
            if (rx_valid1) v1 = c;
            if (c == 2) first1 = ser_out1;
            tick();
        end
        check("A5 line bits", 32'(seq), 32'(11'b11010010100));
        check("A5 rx_valid cycle", 32'(v0), 32'(11));
        check("A5 rx_data", 32'(rx_data0), 32'(8'hA5));
        check("A5 rx_perr", 32'(rx_perr0), 32'(0));
        check("1234 first data bit", 32'(first1), 32'(0));
        check("1234 rx_valid cycle", 32'(v1), 32'(18));
        check("1234 rx_data", 32'(rx_data1), 32'(16'h1234));
        check("1234 rx_perr", 32'(rx_perr1), 32'(0));
        repeat (3) tick();

        // External frame 0x3C with a wrong parity bit.
        loopback = 1'b0;
        fb = 10'b1001111001;
        n = 0; got = '0; gp = 1'b0;
        for (int c = 0; c < 30; c++) begin
            ser_in = (c < 10) ? fb[9-c] : 1'b0;
            @(negedge clk);
            if (rx_valid0) begin
                n++;
                got = rx_data0;
                gp  = rx_perr0;
            end
            tick();
        end
        check("3C pulse count", 32'(n), 32'(1));
        check("3C rx_data", 32'(got), 32'(8'h3C));
        check("3C rx_perr", 32'(gp), 32'(1));
        loopback = 1'b1;
        tick();

        // Back-to-back frames with tx_valid held.
        tx_valid = 1'b1;
        tx_data0 = 8'h01;
        tick();
        tx_data0 = 8'hFF;
        n = 0; bad = 0;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c <= 24 && tx_ready0 != (c == 12 || c == 24)) bad++;
            if (rx_valid0 && n < 4) begin
                got_d[n] = rx_data0;
                got_p[n] = rx_perr0;
                got_c[n] = c;
                n++;
            end
            tick();
            if (c == 12) tx_valid = 1'b0;
        end
        check("b2b tx_ready cadence errors", 32'(bad), 32'(0));
        check("b2b pulse count", 32'(n), 32'(2));
        check("b2b first {cycle,data,perr}", 32'({got_c[0][7:0], got_d[0], 7'b0, got_p[0]}),
              32'({8'd11, 8'h01, 8'h00}));
        check("b2b second {cycle,data,perr}", 32'({got_c[1][7:0], got_d[1], 7'b0, got_p[1]}),
              32'({8'd23, 8'hFF, 8'h00}));

        // Reset asserted while 0x5A is on DATA bit 4.
        repeat (10) tick();
        tx_valid = 1'b1;
        tx_data0 = 8'h5A;
        tick();
        tx_valid = 1'b0;
        repeat (5) tick();
        check("5A bit4 before reset {ser_out,busy}", 32'({ser_out0, tx_busy0}), 32'(2'b11));
        rst_n = 1'b0;
        #1;
        check("abort ser_out", 32'(ser_out0), 32'(0));
        check("abort tx_busy", 32'(tx_busy0), 32'(0));
        tick();
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (rx_valid0) n++;
            tick();
        end
        check("abort no rx_valid", 32'(n), 32'(0));
        tx_valid = 1'b1;
        tx_data0 = 8'h81;
        tick();
        tx_valid = 1'b0;
        v0 = 0; got = '0; gp = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (rx_valid0) begin
                v0  = c;
                got = rx_data0;
                gp  = rx_perr0;
            end
            tick();
        end
        check("81 rx_valid cycle", 32'(v0), 32'(11));
        check("81 rx_data", 32'(got), 32'(8'h81));
        check("81 rx_perr", 32'(gp), 32'(0));

        // Idle line for 50 cycles.
        repeat (10) tick();
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (ser_out0 || !tx_ready0 || rx_valid0) bad++;
            if (ser_out1 || !tx_ready1 || rx_valid1) bad++;
            tick();
        end
        check("idle 50 cycles errors", 32'(bad), 32'(0));

        // Random traffic, loopback flips, line noise and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_data0 = 8'($urandom);
            tx_data1 = 16'($urandom);
            if ($urandom_range(0, 63) == 0) loopback = ~loopback;
            ser_in = ($urandom_range(0, 2) == 0);
            rst_n  = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n = 1'b1;
        tx_valid = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
